text_vmem: RTL and testbench

- Parametrised character-cell display memory between the PS/2 key path and the VGA text renderer.
- Accepts ASCII codes through a valid/ready handshake and maintains a cursor.
- Handles printable characters, ENTER, BACKSPACE and line wrap, and scrolls by rotating a top-row pointer rather than copying memory.
- Serves glyph lookups to the renderer through a registered read port.

---
 rtl/text_pkg.sv | 15 +
 rtl/text_ram.sv | 23 ++
 rtl/text_vmem.sv | 177 +++++++++++++++++
 tb/tb_text_vmem.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared constants and FSM state type for the character-cell display memory.
package text_pkg;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_TILDE = 8'h7E;

  typedef enum logic [1:0] {
    INIT_CLR,
    IDLE,
    LINE_CLR
  } state_t;

endpackage

// File: rtl/text_ram.sv
// Byte-wide character store: one write port, one registered read port.
module text_ram #(
  parameter int DEPTH = 2100,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // NOTE: storage has no reset so it maps onto block RAM; the clear FSM zeroes it instead.
  // A read of the cell being written returns the old byte (read-before-write).
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_vmem.sv
// Text-mode display memory: key-driven cursor/editing FSM, scroll by rotating
// the top-row pointer, and a registered glyph lookup port for the renderer.
module text_vmem
  import text_pkg::*;
#(
  parameter int COLS        = 70,
  parameter int ROWS        = 30,
  parameter int CELL_H_LOG2 = 4,
  parameter int XW          = 7,
  parameter int YW          = 5,
  parameter int VW          = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             key_in,
  input  logic                   p_valid,
  output logic                   p_ready,
  input  logic                   clr,
  input  logic [XW-1:0]          x,
  input  logic [YW-1:0]          y,
  input  logic [VW-1:0]          v_line,
  output logic [7:0]             ascii_out,
  output logic [CELL_H_LOG2-1:0] glyph_row,
  output logic [XW-1:0]          cur_x,
  output logic [YW-1:0]          cur_y,
  output logic                   busy
);

  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [XW-1:0] LAST_COL  = XW'(COLS - 1);
  localparam logic [YW-1:0] LAST_ROW  = YW'(ROWS - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  function automatic logic [YW-1:0] phys_row(input logic [YW-1:0] scr, input logic [YW-1:0] t);
    logic [YW:0] s;
    s = {1'b0, scr} + {1'b0, t};
    if (s >= (YW+1)'(ROWS)) s = s - (YW+1)'(ROWS);
    return s[YW-1:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [YW-1:0] row, input logic [XW-1:0] col);
    return AW'(row) * AW'(COLS) + AW'(col);
  endfunction

  state_t        state, state_n;
  logic [XW-1:0] cur_x_n, line_cnt, line_cnt_n;
  logic [YW-1:0] cur_y_n, top, top_n, clr_row, clr_row_n;
  logic [AW-1:0] clr_addr, clr_addr_n;
  logic          do_newline;
  logic          we;
  logic [AW-1:0] waddr, raddr;
  logic [7:0]    wdata, rdata;
  logic          rd_oob, rd_oob_q;
  logic          unused_ok;

  assign unused_ok = ^v_line;
  assign busy      = (state != IDLE);
  assign p_ready   = (state == IDLE) && !clr;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_n    = state;
    cur_x_n    = cur_x;
    cur_y_n    = cur_y;
    top_n      = top;
    clr_addr_n = clr_addr;
    line_cnt_n = line_cnt;
    clr_row_n  = clr_row;
    do_newline = 1'b0;
    we         = 1'b0;
    waddr      = '0;
    wdata      = 8'h00;

    case (state)
      INIT_CLR: begin
        we         = 1'b1;
        waddr      = clr_addr;
        clr_addr_n = clr_addr + AW'(1);
        if (clr_addr == LAST_ADDR) state_n = IDLE;
      end
      LINE_CLR: begin
        we         = 1'b1;
        waddr      = cell_addr(clr_row, line_cnt);
        line_cnt_n = line_cnt + XW'(1);
        if (line_cnt == LAST_COL) state_n = IDLE;
      end
      IDLE: begin
        if (clr) begin
          state_n    = INIT_CLR;
          clr_addr_n = '0;
          cur_x_n    = '0;
          cur_y_n    = '0;
          top_n      = '0;
        end else if (p_valid) begin
          if (key_in >= ASCII_SPACE && key_in <= ASCII_TILDE) begin
            we    = 1'b1;
            waddr = cell_addr(phys_row(cur_y, top), cur_x);
            wdata = key_in;
            if (cur_x == LAST_COL) do_newline = 1'b1;
            else                   cur_x_n    = cur_x + XW'(1);
          end else if (key_in == ASCII_LF) begin
            do_newline = 1'b1;
          end else if (key_in == ASCII_BS) begin
            if (cur_x != '0) begin
              cur_x_n = cur_x - XW'(1);
              we      = 1'b1;
              waddr   = cell_addr(phys_row(cur_y, top), cur_x - XW'(1));
            end else if (cur_y != '0) begin
              cur_y_n = cur_y - YW'(1);
              cur_x_n = LAST_COL;
              we      = 1'b1;
              waddr   = cell_addr(phys_row(cur_y - YW'(1), top), LAST_COL);
            end
          end
        end
      end
      default: state_n = INIT_CLR;
    endcase

    // On the bottom row a newline rotates the top pointer; the old top row becomes the new bottom.
    if (do_newline) begin
      cur_x_n = '0;
      if (cur_y != LAST_ROW) begin
        cur_y_n = cur_y + YW'(1);
      end else begin
        top_n      = (top == LAST_ROW) ? '0 : top + YW'(1);
        clr_row_n  = top;
        line_cnt_n = '0;
        state_n    = LINE_CLR;
      end
    end
  end

  assign rd_oob = ({1'b0, x} >= (XW+1)'(COLS)) || ({1'b0, y} >= (YW+1)'(ROWS));
  assign raddr  = rd_oob ? '0 : cell_addr(phys_row(y, top), x);

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT_CLR;
      cur_x     <= '0;
      cur_y     <= '0;
      top       <= '0;
      clr_addr  <= '0;
      line_cnt  <= '0;
      clr_row   <= '0;
      rd_oob_q  <= 1'b1;
      glyph_row <= '0;
    end else begin
      state     <= state_n;
      cur_x     <= cur_x_n;
      cur_y     <= cur_y_n;
      top       <= top_n;
      clr_addr  <= clr_addr_n;
      line_cnt  <= line_cnt_n;
      clr_row   <= clr_row_n;
      rd_oob_q  <= rd_oob;
      glyph_row <= v_line[CELL_H_LOG2-1:0];
    end
  end

  assign ascii_out = (state == INIT_CLR || rd_oob_q) ? 8'h00 : rdata;

  text_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_text_vmem.sv
// Directed bench for text_vmem on a 4x3 screen: clear timing, typing, backspace,
// scrolling, clear priority, reset during a line clear and out-of-range reads.
module tb_text_vmem;

  localparam int COLS = 4, ROWS = 3, CH = 4, XW = 3, YW = 2, VW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    key_in = 8'h00;
  logic          p_valid = 1'b0;
  logic          clr = 1'b0;
  logic [XW-1:0] x = '0;
  logic [YW-1:0] y = '0;
  logic [VW-1:0] v_line = '0;
  logic          p_ready, busy;
  logic [7:0]    ascii_out;
  logic [CH-1:0] glyph_row;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;

  int vectors = 0;
  int miscompares = 0;

  text_vmem #(
    .COLS(COLS), .ROWS(ROWS), .CELL_H_LOG2(CH), .XW(XW), .YW(YW), .VW(VW)
  ) dut (
    .clk(clk), .reset(reset), .key_in(key_in), .p_valid(p_valid), .p_ready(p_ready),
    .clr(clr), .x(x), .y(y), .v_line(v_line), .ascii_out(ascii_out),
    .glyph_row(glyph_row), .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [7:0] k);
    int n = 0;
    while (!p_ready && n < 100) begin tick(); n++; end
    if (!p_ready) begin
      vectors++; miscompares++;
      $display("FAIL send_key_timeout: p_ready=%b want 1", p_ready);
    end
    key_in = k; p_valid = 1'b1;
    tick();
    p_valid = 1'b0;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 200) begin tick(); n++; end
  endtask

  task automatic read_cell(input int cx, input int cy, output logic [7:0] d);
    x = XW'(cx); y = YW'(cy);
    tick();
    d = ascii_out;
  endtask

  task automatic test_reset();
    int n;
    logic [7:0] d;
    v_line = 10'h005;
    reset = 1'b1; tick(); reset = 1'b0;
    vectors++; if (busy !== 1'b1 || p_ready !== 1'b0) begin miscompares++;
      $display("FAIL reset_flags: busy=%b p_ready=%b want 1/0", busy, p_ready); end
    vectors++; if (glyph_row !== 4'h0 || ascii_out !== 8'h00) begin miscompares++;
      $display("FAIL reset_outputs: glyph_row=%h ascii_out=%h want 0/00", glyph_row, ascii_out); end
    vectors++; if (cur_x !== 3'd0 || cur_y !== 2'd0) begin miscompares++;
      $display("FAIL reset_cursor: got (%0d,%0d) want (0,0)", cur_x, cur_y); end
    wait_busy(n);
    vectors++; if (n != 12) begin miscompares++;
      $display("FAIL reset_clear_len: got %0d cycles want 12", n); end
    vectors++; if (p_ready !== 1'b1) begin miscompares++;
      $display("FAIL reset_ready: got %b want 1", p_ready); end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        read_cell(c, r, d);
        vectors++; if (d !== 8'h00) begin miscompares++;
          $display("FAIL reset_cell(%0d,%0d): got %h want 00", c, r, d); end
      end
  endtask

  task automatic test_glyph_row();
    v_line = 10'h3A7; tick();
    vectors++; if (glyph_row !== 4'h7) begin miscompares++;
      $display("FAIL glyph_row_3A7: got %h want 7", glyph_row); end
    v_line = 10'h010; tick();
    vectors++; if (glyph_row !== 4'h0) begin miscompares++;
      $display("FAIL glyph_row_010: got %h want 0", glyph_row); end
  endtask

  task automatic test_typing();
    logic [7:0] d;
    logic [7:0] exp_row [4] = '{8'h41, 8'h42, 8'h43, 8'h44};
    x = '0; y = '0;
    send_key(8'h41);
    vectors++; if (ascii_out !== 8'h00) begin miscompares++;
      $display("FAIL read_during_write: got %h want old 00", ascii_out); end
    tick();
    vectors++; if (ascii_out !== 8'h41) begin miscompares++;
      $display("FAIL read_after_write: got %h want 41", ascii_out); end
    send_key(8'h42); send_key(8'h43); send_key(8'h44);
    vectors++; if (cur_x !== 3'd0 || cur_y !== 2'd1) begin miscompares++;
      $display("FAIL typing_wrap_cursor: got (%0d,%0d) want (0,1)", cur_x, cur_y); end
    for (int c = 0; c < COLS; c++) begin
      read_cell(c, 0, d);
      vectors++; if (d !== exp_row[c]) begin miscompares++;
        $display("FAIL typing_cell(%0d,0): got %h want %h", c, d, exp_row[c]); end
    end
    read_cell(0, 0, d);
    x = 3'd1; y = 2'd0; #1;
    vectors++; if (ascii_out !== 8'h41) begin miscompares++;
      $display("FAIL read_latency_hold: got %h want 41", ascii_out); end
    tick();
    vectors++; if (ascii_out !== 8'h42) begin miscompares++;
      $display("FAIL read_latency_one: got %h want 42", ascii_out); end
  endtask

  task automatic test_backspace();
    logic [7:0] d;
    send_key(8'h45); send_key(8'h46);
    send_key(8'h08);
    vectors++; if (cur_x !== 3'd1 || cur_y !== 2'd1) begin miscompares++;
      $display("FAIL bs_mid_cursor: got (%0d,%0d) want (1,1)", cur_x, cur_y); end
    read_cell(1, 1, d);
    vectors++; if (d !== 8'h00) begin miscompares++;
      $display("FAIL bs_mid_cell: got %h want 00", d); end
    read_cell(0, 1, d);
    vectors++; if (d !== 8'h45) begin miscompares++;
      $display("FAIL bs_neighbour_cell: got %h want 45", d); end
    send_key(8'h08);
    send_key(8'h08);
    vectors++; if (cur_x !== 3'd3 || cur_y !== 2'd0) begin miscompares++;
      $display("FAIL bs_wrap_cursor: got (%0d,%0d) want (3,0)", cur_x, cur_y); end
    read_cell(3, 0, d);
    vectors++; if (d !== 8'h00) begin miscompares++;
      $display("FAIL bs_wrap_cell: got %h want 00", d); end
    read_cell(2, 0, d);
    vectors++; if (d !== 8'h43) begin miscompares++;
      $display("FAIL bs_wrap_neighbour: got %h want 43", d); end
    send_key(8'h08); send_key(8'h08); send_key(8'h08);
    send_key(8'h08);
    vectors++; if (cur_x !== 3'd0 || cur_y !== 2'd0) begin miscompares++;
      $display("FAIL bs_home_noop: got (%0d,%0d) want (0,0)", cur_x, cur_y); end
    send_key(8'h01); send_key(8'h7F);
    vectors++; if (cur_x !== 3'd0 || cur_y !== 2'd0 || p_ready !== 1'b1) begin miscompares++;
      $display("FAIL discard_codes: cur=(%0d,%0d) p_ready=%b want (0,0) 1", cur_x, cur_y, p_ready); end
    read_cell(0, 0, d);
    vectors++; if (d !== 8'h00) begin miscompares++;
      $display("FAIL discard_no_write: got %h want 00", d); end
    send_key(8'h7E);
    vectors++; if (cur_x !== 3'd1 || cur_y !== 2'd0) begin miscompares++;
      $display("FAIL tilde_cursor: got (%0d,%0d) want (1,0)", cur_x, cur_y); end
    read_cell(0, 0, d);
    vectors++; if (d !== 8'h7E) begin miscompares++;
      $display("FAIL tilde_cell: got %h want 7E", d); end
    send_key(8'h08);
  endtask

  task automatic test_scroll();
    int n;
    logic [7:0] d;
    logic [7:0] exp1 [12] = '{8'h65,8'h66,8'h67,8'h68, 8'h69,8'h6A,8'h6B,8'h00, 8'h00,8'h00,8'h00,8'h00};
    logic [7:0] exp2 [12] = '{8'h69,8'h6A,8'h6B,8'h00, 8'h6D,8'h6E,8'h6F,8'h70, 8'h00,8'h00,8'h00,8'h00};
    logic [7:0] exp3 [12] = '{8'h6D,8'h6E,8'h6F,8'h70, 8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00,8'h00};
    for (int i = 0; i < 11; i++) send_key(8'h61 + 8'(i));
    vectors++; if (cur_x !== 3'd3 || cur_y !== 2'd2) begin miscompares++;
      $display("FAIL fill_cursor: got (%0d,%0d) want (3,2)", cur_x, cur_y); end
    send_key(8'h0A);
    vectors++; if (p_ready !== 1'b0) begin miscompares++;
      $display("FAIL scroll_ready_low: got %b want 0", p_ready); end
    wait_busy(n);
    vectors++; if (n != 4) begin miscompares++;
      $display("FAIL scroll_line_clr_len: got %0d cycles want 4", n); end
    vectors++; if (cur_x !== 3'd0 || cur_y !== 2'd2) begin miscompares++;
      $display("FAIL scroll_cursor: got (%0d,%0d) want (0,2)", cur_x, cur_y); end
    for (int i = 0; i < 12; i++) begin
      read_cell(i % COLS, i / COLS, d);
      vectors++; if (d !== exp1[i]) begin miscompares++;
        $display("FAIL scroll1_cell(%0d,%0d): got %h want %h", i % COLS, i / COLS, d, exp1[i]); end
    end
    for (int i = 0; i < 4; i++) send_key(8'h6D + 8'(i));
    wait_busy(n);
    vectors++; if (n != 4 || cur_x !== 3'd0 || cur_y !== 2'd2) begin miscompares++;
      $display("FAIL wrap_scroll: cycles=%0d cur=(%0d,%0d) want 4 (0,2)", n, cur_x, cur_y); end
    for (int i = 0; i < 12; i++) begin
      read_cell(i % COLS, i / COLS, d);
      vectors++; if (d !== exp2[i]) begin miscompares++;
        $display("FAIL scroll2_cell(%0d,%0d): got %h want %h", i % COLS, i / COLS, d, exp2[i]); end
    end
    send_key(8'h0A);
    wait_busy(n);
    for (int i = 0; i < 12; i++) begin
      read_cell(i % COLS, i / COLS, d);
      vectors++; if (d !== exp3[i]) begin miscompares++;
        $display("FAIL scroll3_cell(%0d,%0d): got %h want %h", i % COLS, i / COLS, d, exp3[i]); end
    end
  endtask

  task automatic test_clr_priority();
    int n;
    logic [7:0] d;
    send_key(8'h0A);
    wait_busy(n);
    clr = 1'b1; p_valid = 1'b1; key_in = 8'h5A;
    #1;
    vectors++; if (p_ready !== 1'b0) begin miscompares++;
      $display("FAIL clr_blocks_ready: got %b want 0", p_ready); end
    tick();
    clr = 1'b0; p_valid = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++;
      $display("FAIL clr_busy: got %b want 1", busy); end
    tick(); tick(); tick();
    clr = 1'b1; tick(); clr = 1'b0;
    wait_busy(n);
    vectors++; if (n != 8) begin miscompares++;
      $display("FAIL clr_ignored_when_busy: remaining %0d cycles want 8", n); end
    vectors++; if (cur_x !== 3'd0 || cur_y !== 2'd0) begin miscompares++;
      $display("FAIL clr_cursor: got (%0d,%0d) want (0,0)", cur_x, cur_y); end
    for (int i = 0; i < 12; i++) begin
      read_cell(i % COLS, i / COLS, d);
      vectors++; if (d !== 8'h00) begin miscompares++;
        $display("FAIL clr_cell(%0d,%0d): got %h want 00", i % COLS, i / COLS, d); end
    end
  endtask

  task automatic test_reset_mid_line_clr();
    int n;
    logic [7:0] d;
    send_key(8'h41); send_key(8'h42); send_key(8'h0A); send_key(8'h43); send_key(8'h44);
    read_cell(1, 1, d);
    vectors++; if (d !== 8'h44) begin miscompares++;
      $display("FAIL oob_sanity: got %h want 44", d); end
    read_cell(5, 0, d);
    vectors++; if (d !== 8'h00) begin miscompares++;
      $display("FAIL oob_x5: got %h want 00", d); end
    read_cell(4, 0, d);
    vectors++; if (d !== 8'h00) begin miscompares++;
      $display("FAIL oob_x4: got %h want 00", d); end
    read_cell(0, 3, d);
    vectors++; if (d !== 8'h00) begin miscompares++;
      $display("FAIL oob_y3: got %h want 00", d); end
    send_key(8'h0A); send_key(8'h0A);
    tick();
    vectors++; if (busy !== 1'b1) begin miscompares++;
      $display("FAIL line_clr_busy: got %b want 1", busy); end
    reset = 1'b1; tick(); reset = 1'b0;
    wait_busy(n);
    vectors++; if (n != 12) begin miscompares++;
      $display("FAIL reset_mid_clear_len: got %0d cycles want 12", n); end
    vectors++; if (cur_x !== 3'd0 || cur_y !== 2'd0 || p_ready !== 1'b1) begin miscompares++;
      $display("FAIL reset_mid_state: cur=(%0d,%0d) p_ready=%b want (0,0) 1", cur_x, cur_y, p_ready); end
    for (int i = 0; i < 12; i++) begin
      read_cell(i % COLS, i / COLS, d);
      vectors++; if (d !== 8'h00) begin miscompares++;
        $display("FAIL reset_mid_cell(%0d,%0d): got %h want 00", i % COLS, i / COLS, d); end
    end
  endtask

  initial begin
    test_reset();
    test_glyph_row();
    test_typing();
    test_backspace();
    test_scroll();
    test_clr_priority();
    test_reset_mid_line_clr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
